// File: rtl/title_pkg.sv
// Shared types and helpers for the title-text compositor.
package title_pkg;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    localparam int unsigned ALPHA_MAX = 16;

    typedef logic [11:0] rgb12_t;

    // One 4-bit channel: (t*a + b*(16-a)) >> 4, truncating; the sum never exceeds 240.
    function automatic logic [3:0] blend4(input logic [3:0] t,
                                          input logic [3:0] b,
                                          input logic [4:0] a);
        logic [8:0] pt;
        logic [8:0] pb;
        logic [8:0] s;
        pt = 9'(t) * 9'(a);
        pb = 9'(b) * 9'(5'(ALPHA_MAX) - a);
        s  = pt + pb;
        return s[7:4];
    endfunction

endpackage

// File: rtl/title_fade_ctrl.sv
// Frame-synchronous fade controller: HIDDEN/FADE_IN/SHOWN/FADE_OUT FSM, frame divider
// for alpha steps and, when TITLE_BLINK_EN is defined, a blink phase counter in SHOWN.
module title_fade_ctrl
    import title_pkg::*;
#(
    parameter int unsigned FADE_FRAMES  = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       show,
    output logic [4:0] alpha,
    output logic [4:0] eff_alpha,
    output logic       fade_busy
);

    localparam int unsigned DIV_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_FRAMES - 1);
    localparam logic [4:0] A_MAX = 5'(ALPHA_MAX);

    fade_state_t      state_q, state_d;
    logic [4:0]       alpha_q, alpha_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Next-state: everything moves only on a frame tick; reversals do not step alpha.
    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        div_d   = div_q;
        if (frame_tick) begin
            unique case (state_q)
                HIDDEN: begin
                    div_d = '0;
                    if (show) state_d = FADE_IN;
                end
                FADE_IN: begin
                    if (!show) begin
                        state_d = FADE_OUT;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (alpha_q < A_MAX) alpha_d = alpha_q + 5'd1;
                        if (alpha_q >= A_MAX - 5'd1) state_d = SHOWN;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                SHOWN: begin
                    div_d = '0;
                    if (!show) state_d = FADE_OUT;
                end
                FADE_OUT: begin
                    if (show) begin
                        state_d = FADE_IN;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (alpha_q > 5'd0) alpha_d = alpha_q - 5'd1;
                        if (alpha_q <= 5'd1) state_d = HIDDEN;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = HIDDEN;
                    alpha_d = '0;
                    div_d   = '0;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= HIDDEN;
            alpha_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            alpha_q <= alpha_d;
            div_q   <= div_d;
        end
    end

    assign alpha     = alpha_q;
    assign fade_busy = (state_q == FADE_IN) || (state_q == FADE_OUT);

`ifdef TITLE_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;

    // Blink counter: runs on ticks that stay in SHOWN, cleared whenever SHOWN is left.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (state_d != SHOWN) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (frame_tick && state_q == SHOWN) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Blink state register.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Off phase hides the text without disturbing the reported alpha.
    assign eff_alpha = phase_q ? 5'd0 : alpha_q;
`else
    assign eff_alpha = alpha_q;
`endif

endmodule

// File: rtl/title_text_compositor.sv
// Title-text compositor: windows, colour-keys and alpha-blends the text stream over the
// background stream, two-cycle latency from DrawX/DrawY/blank to the registered RGB outputs.
// Optional blink in SHOWN is enabled by defining TITLE_BLINK_EN.
module title_text_compositor
    import title_pkg::*;
#(
    parameter int unsigned WIN_X0       = 206,
    parameter int unsigned WIN_Y0       = 100,
    parameter int unsigned WIN_W        = 227,
    parameter int unsigned WIN_H        = 35,
    parameter logic [11:0] KEY_COLOR    = 12'hF0F,
    parameter int unsigned FADE_FRAMES  = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic [3:0] text_red,
    input  logic [3:0] text_green,
    input  logic [3:0] text_blue,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    input  logic       show,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [4:0] alpha,
    output logic       fade_busy
);

    localparam logic [10:0] X_LO = 11'(WIN_X0);
    localparam logic [10:0] X_HI = 11'(WIN_X0 + WIN_W - 1);
    localparam logic [10:0] Y_LO = 11'(WIN_Y0);
    localparam logic [10:0] Y_HI = 11'(WIN_Y0 + WIN_H - 1);

    logic [9:0] dx_q, dy_q;
    logic       blank_q;
    logic [3:0] red_q, green_q, blue_q;
    logic [3:0] red_d, green_d, blue_d;
    logic       frame_tick;
    logic [4:0] eff_alpha;
    logic       hit;
    logic       keyed;
    rgb12_t     text_px;

    // Undelayed coordinates: the new alpha is in place before pixel (0,0) is blended.
    assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0);

    title_fade_ctrl #(
        .FADE_FRAMES (FADE_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_fade_ctrl (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .show      (show),
        .alpha     (alpha),
        .eff_alpha (eff_alpha),
        .fade_busy (fade_busy)
    );

    // Delay coordinates and blank one stage to line up with the text/background pixels.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            dx_q    <= '0;
            dy_q    <= '0;
            blank_q <= 1'b0;
        end else begin
            dx_q    <= DrawX;
            dy_q    <= DrawY;
            blank_q <= blank;
        end
    end

    assign text_px = {text_red, text_green, text_blue};
    assign keyed   = (text_px == KEY_COLOR);
    assign hit     = ({1'b0, dx_q} >= X_LO) && ({1'b0, dx_q} <= X_HI) &&
                     ({1'b0, dy_q} >= Y_LO) && ({1'b0, dy_q} <= Y_HI);

    // Blend datapath: blanking wins, then window/key select background, else mix.
    always_comb begin
        red_d   = 4'd0;
        green_d = 4'd0;
        blue_d  = 4'd0;
        if (blank_q) begin
            if (!hit || keyed) begin
                red_d   = bg_red;
                green_d = bg_green;
                blue_d  = bg_blue;
            end else begin
                red_d   = blend4(text_red,   bg_red,   eff_alpha);
                green_d = blend4(text_green, bg_green, eff_alpha);
                blue_d  = blend4(text_blue,  bg_blue,  eff_alpha);
            end
        end
    end

    // Output register driving the VGA pins.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: tb/tb_title_text_compositor.sv
// Self-checking bench for title_text_compositor (FADE_FRAMES=1, BLINK_FRAMES=2).
module tb_title_text_compositor;

    localparam int WX0 = 206;
    localparam int WY0 = 100;
    localparam int WW  = 227;
    localparam int WH  = 35;
    localparam logic [11:0] KEY = 12'hF0F;
    localparam int BF  = 2;
`ifdef TITLE_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       vga_clk = 1'b0;
    logic       reset;
    logic [9:0] DrawX, DrawY;
    logic       blank;
    logic [3:0] text_red, text_green, text_blue;
    logic [3:0] bg_red, bg_green, bg_blue;
    logic       show;
    logic [3:0] red, green, blue;
    logic [4:0] alpha;
    logic       fade_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: alpha level, direction of travel, ticks spent resting at full alpha.
    int m_alpha;
    int m_dir;
    bit m_full;
    int m_full_ticks;

    always #5 vga_clk = ~vga_clk;

    title_text_compositor #(
        .FADE_FRAMES (1),
        .BLINK_FRAMES(BF)
    ) dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .text_red  (text_red),
        .text_green(text_green),
        .text_blue (text_blue),
        .bg_red    (bg_red),
        .bg_green  (bg_green),
        .bg_blue   (bg_blue),
        .show      (show),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .alpha     (alpha),
        .fade_busy (fade_busy)
    );

    function automatic void model_reset();
        m_alpha = 0;
        m_dir = -1;
        m_full = 1'b0;
        m_full_ticks = 0;
    endfunction

    function automatic void model_tick(input bit s);
        int want;
        int na;
        want = s ? 1 : -1;
        if (want != m_dir) begin
            m_dir = want;
            m_full = 1'b0;
            m_full_ticks = 0;
        end else if (m_full) begin
            m_full_ticks++;
        end else begin
            na = m_alpha + m_dir;
            if (na > 16) na = 16;
            if (na < 0) na = 0;
            if (m_dir == 1 && na == 16) begin
                m_full = 1'b1;
                m_full_ticks = 0;
            end
            m_alpha = na;
        end
    endfunction

    function automatic bit model_busy();
        return (m_dir == 1 && m_alpha < 16) || (m_dir == -1 && m_alpha > 0);
    endfunction

    function automatic int model_eff();
        if (BLINK_ON && m_full && ((m_full_ticks / BF) % 2 == 1)) return 0;
        return m_alpha;
    endfunction

    function automatic logic [11:0] exp_pix(input int x, input int y, input bit b,
                                            input logic [11:0] t, input logic [11:0] g,
                                            input int a);
        logic [11:0] r;
        int tc;
        int gc;
        if (!b) return 12'h000;
        if (x < WX0 || x > WX0 + WW - 1 || y < WY0 || y > WY0 + WH - 1 || t == KEY) return g;
        for (int c = 0; c < 3; c++) begin
            tc = int'(t[c*4 +: 4]);
            gc = int'(g[c*4 +: 4]);
            r[c*4 +: 4] = 4'((tc * a + gc * (16 - a)) / 16);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic park();
        DrawX = 10'd1;
        DrawY = 10'd1;
        blank = 1'b0;
    endtask

    // One frame boundary: pixel (0,0) presented for a single cycle.
    task automatic tick(input bit s);
        show = s;
        DrawX = 10'd0;
        DrawY = 10'd0;
        blank = 1'b0;
        step();
        model_tick(s);
        park();
    endtask

    task automatic probe(input int x, input int y, input bit b, input logic [11:0] t,
                         input logic [11:0] g, output logic [11:0] obs);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        step();
        park();
        {text_red, text_green, text_blue} = t;
        {bg_red, bg_green, bg_blue} = g;
        step();
        obs = {red, green, blue};
    endtask

    function automatic logic [11:0] rnd_text();
        logic [11:0] t;
        t = 12'($urandom);
        if (t == KEY) t = 12'h0F0;
        return t;
    endfunction

    task automatic test_reset();
        logic [11:0] obs;
        logic [11:0] exp;
        reset = 1'b1;
        show = 1'b0;
        park();
        {text_red, text_green, text_blue} = 12'hFFF;
        {bg_red, bg_green, bg_blue} = 12'hABC;
        step();
        step();
        reset = 1'b0;
        model_reset();
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rgb got=%h exp=000", {red, green, blue});
        end
        n_checks++;
        if (alpha !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_alpha got=%0d exp=0", alpha);
        end
        n_checks++;
        if (fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%0b exp=0", fade_busy);
        end
        probe(WX0 + 5, WY0 + 5, 1'b1, 12'hFFF, 12'h123, obs);
        n_checks++;
        if (obs !== 12'h123) begin
            n_fail++;
            $display("FAIL hidden_bg got=%h exp=123", obs);
        end
        tick(1'b0);
        exp = exp_pix(WX0 + 9, WY0 + 9, 1'b1, 12'hFFF, 12'h456, model_eff());
        probe(WX0 + 9, WY0 + 9, 1'b1, 12'hFFF, 12'h456, obs);
        n_checks++;
        if (obs !== exp || alpha !== 5'd0 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hidden_stay got=%h/%0d/%0b exp=%h/0/0", obs, alpha, fade_busy, exp);
        end
    endtask

    task automatic test_fade_in();
        logic [11:0] obs;
        logic [11:0] t;
        logic [11:0] g;
        logic [11:0] exp;
        int x;
        int y;
        for (int i = 0; i < 17; i++) begin
            // show dips between ticks must be ignored
            show = 1'b0;
            step();
            step();
            tick(1'b1);
            n_checks++;
            if (alpha !== 5'(m_alpha) || fade_busy !== model_busy()) begin
                n_fail++;
                $display("FAIL fade_in_step%0d got=%0d/%0b exp=%0d/%0b", i, alpha, fade_busy,
                         m_alpha, model_busy());
            end
            if (m_alpha == 8) begin
                probe(WX0 + 20, WY0 + 10, 1'b1, 12'hF00, 12'h00F, obs);
                n_checks++;
                if (obs !== 12'h707) begin
                    n_fail++;
                    $display("FAIL blend_a8 got=%h exp=707", obs);
                end
            end
            x = WX0 + int'($urandom_range(0, WW - 1));
            y = WY0 + int'($urandom_range(0, WH - 1));
            t = rnd_text();
            g = 12'($urandom);
            exp = exp_pix(x, y, 1'b1, t, g, model_eff());
            probe(x, y, 1'b1, t, g, obs);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL fade_in_pix%0d got=%h exp=%h a=%0d", i, obs, exp, m_alpha);
            end
        end
        n_checks++;
        if (alpha !== 5'd16 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL shown_reached got=%0d/%0b exp=16/0", alpha, fade_busy);
        end
    endtask

    task automatic test_shown_edges();
        int xs[9];
        int ys[9];
        bit bs[9];
        bit ks[9];
        logic [11:0] obs;
        logic [11:0] t;
        logic [11:0] g;
        logic [11:0] exp;
        xs = '{WX0 + 30, WX0 - 1, WX0 + 30, WX0, WX0 + WW - 1, WX0 + WW, WX0, WX0, WX0 + 3};
        ys = '{WY0 + 5, WY0, WY0 + 5, WY0, WY0 + WH - 1, WY0, WY0 + WH, WY0 - 1, WY0 + WH - 1};
        bs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ks = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            t = ks[i] ? KEY : rnd_text();
            g = 12'($urandom);
            if (g == t) g = ~t;
            exp = exp_pix(xs[i], ys[i], bs[i], t, g, model_eff());
            probe(xs[i], ys[i], bs[i], t, g, obs);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL shown_edge%0d got=%h exp=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_blink();
        logic [11:0] obs;
        logic [11:0] t;
        logic [11:0] g;
        logic [11:0] exp;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            t = rnd_text();
            g = 12'($urandom);
            if (g == t) g = ~t;
            exp = exp_pix(WX0 + 50, WY0 + 7, 1'b1, t, g, model_eff());
            probe(WX0 + 50, WY0 + 7, 1'b1, t, g, obs);
            n_checks++;
            if (obs !== exp || alpha !== 5'd16) begin
                n_fail++;
                $display("FAIL blink_frame%0d got=%h/%0d exp=%h/16", i, obs, alpha, exp);
            end
        end
    endtask

    task automatic test_reversal();
        // Full fade out, then fade in to 10 and reverse.
        for (int i = 0; i < 18; i++) begin
            tick(1'b0);
            n_checks++;
            if (alpha !== 5'(m_alpha) || fade_busy !== model_busy()) begin
                n_fail++;
                $display("FAIL fade_out%0d got=%0d/%0b exp=%0d/%0b", i, alpha, fade_busy,
                         m_alpha, model_busy());
            end
        end
        for (int i = 0; i < 20 && m_alpha < 10; i++) tick(1'b1);
        n_checks++;
        if (alpha !== 5'd10 || fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_10 got=%0d/%0b exp=10/1", alpha, fade_busy);
        end
        for (int i = 0; i < 11; i++) begin
            tick(1'b0);
            n_checks++;
            if (alpha !== 5'(m_alpha) || fade_busy !== model_busy()) begin
                n_fail++;
                $display("FAIL reverse%0d got=%0d/%0b exp=%0d/%0b", i, alpha, fade_busy,
                         m_alpha, model_busy());
            end
        end
        n_checks++;
        if (alpha !== 5'd0 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reverse_end got=%0d/%0b exp=0/0", alpha, fade_busy);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 200;
        int xs[N];
        int ys[N];
        bit bs[N];
        logic [11:0] ts[N];
        logic [11:0] gs[N];
        logic [11:0] exp;
        for (int i = 0; i < 20 && m_alpha < 5; i++) tick(1'b1);
        for (int i = 0; i < N; i++) begin
            xs[i] = WX0 - 8 + int'($urandom_range(0, WW + 16));
            ys[i] = WY0 - 4 + int'($urandom_range(0, WH + 8));
            bs[i] = ($urandom_range(0, 4) != 0);
            ts[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
            gs[i] = 12'($urandom);
        end
        for (int k = 0; k <= N; k++) begin
            if (k < N) begin
                DrawX = 10'(xs[k]);
                DrawY = 10'(ys[k]);
                blank = bs[k];
            end else begin
                park();
            end
            if (k >= 1) begin
                {text_red, text_green, text_blue} = ts[k-1];
                {bg_red, bg_green, bg_blue} = gs[k-1];
            end
            step();
            if (k >= 1) begin
                exp = exp_pix(xs[k-1], ys[k-1], bs[k-1], ts[k-1], gs[k-1], model_eff());
                n_checks++;
                if ({red, green, blue} !== exp) begin
                    n_fail++;
                    $display("FAIL stream%0d got=%h exp=%h", k - 1, {red, green, blue}, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20 && m_alpha < 7; i++) tick(1'b1);
        DrawX = 10'(WX0 + 4);
        DrawY = 10'(WY0 + 4);
        blank = 1'b1;
        {text_red, text_green, text_blue} = 12'hFFF;
        {bg_red, bg_green, bg_blue} = 12'h888;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (alpha !== 5'd0 || fade_busy !== 1'b0 || {red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset got=%0d/%0b/%h exp=0/0/000", alpha, fade_busy,
                     {red, green, blue});
        end
        tick(1'b0);
        n_checks++;
        if (alpha !== 5'd0 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_hidden got=%0d/%0b exp=0/0", alpha, fade_busy);
        end
        tick(1'b1);
        tick(1'b1);
        n_checks++;
        if (alpha !== 5'(m_alpha) || fade_busy !== model_busy()) begin
            n_fail++;
            $display("FAIL mid_reset_restart got=%0d/%0b exp=%0d/%0b", alpha, fade_busy,
                     m_alpha, model_busy());
        end
    endtask

    initial begin
        reset = 1'b1;
        show = 1'b0;
        park();
        {text_red, text_green, text_blue} = 12'h000;
        {bg_red, bg_green, bg_blue} = 12'h000;
        model_reset();
        test_reset();
        test_fade_in();
        test_shown_edges();
        test_blink();
        test_reversal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
